// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types and helpers for the player life controller
package life_pkg;

  typedef enum logic [1:0] {ALIVE, INVULN, GAME_OVER} life_state_t;

  localparam int LIFE_W = 3;

  function automatic logic [LIFE_W-1:0] life_inc(input logic [LIFE_W-1:0] life,
                                                 input logic [LIFE_W-1:0] maxLife);
    return (life >= maxLife) ? maxLife : life + 3'd1;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - loadable frame down-counter; done pulses on the tick that empties it
module frame_timer (
  input  logic       clk,
  input  logic       resetN,
  input  logic       load,
  input  logic [7:0] loadVal,
  input  logic       tick,
  output logic       done
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (tick && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  // Combinational so the owner can leave on the same edge that consumes the last tick.
  assign done = tick && !load && (cnt == 8'd1);

endmodule

// File: rtl/life_manager.sv
// rtl/life_manager.sv - player life count, post-hit invulnerability, blink and game-over
module life_manager
  import life_pkg::*;
#(
  parameter int unsigned INIT_LIFE     = 3,
  parameter int unsigned MAX_LIFE      = 5,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_FRAMES  = 8
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              hitEvent,
  input  logic              lifeGain,
  input  logic              newGame,
  output logic [LIFE_W-1:0] currLife,
  output logic              invulnerable,
  output logic              iconVisible,
  output logic              gameOver
);

  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [LIFE_W-1:0]  INIT_L  = LIFE_W'(INIT_LIFE);
  localparam logic [LIFE_W-1:0]  MAX_L   = LIFE_W'(MAX_LIFE);
  localparam logic [BLINK_W-1:0] BLINK_L = BLINK_W'(BLINK_FRAMES);

  life_state_t        state, stateNext;
  logic [LIFE_W-1:0]  lifeNext;
  logic [BLINK_W-1:0] blinkCnt, blinkNext, blinkInc;
  logic               visNext;
  logic               hitPrev, hit;
  logic               timerLoad, timerTick, timerDone;
  logic [7:0]         timerLoadVal;

  assign hit       = hitEvent & ~hitPrev;
  assign blinkInc  = blinkCnt + BLINK_W'(1);
  assign timerTick = startOfFrame && (state == INVULN);

  frame_timer u_frame_timer (
    .clk     (clk),
    .resetN  (resetN),
    .load    (timerLoad),
    .loadVal (timerLoadVal),
    .tick    (timerTick),
    .done    (timerDone)
  );

  always_comb begin
    stateNext    = state;
    lifeNext     = currLife;
    blinkNext    = blinkCnt;
    visNext      = iconVisible;
    timerLoad    = 1'b0;
    timerLoadVal = 8'd0;
    if (newGame) begin
      stateNext = ALIVE;
      lifeNext  = INIT_L;
      blinkNext = '0;
      visNext   = 1'b1;
      timerLoad = 1'b1;
    end else begin
      case (state)
        ALIVE: begin
          if (hit) begin
            // A simultaneous pickup cancels the hit's cost, including the lethal one.
            if (lifeGain || currLife > 3'd1) begin
              if (!lifeGain) lifeNext = currLife - 3'd1;
              stateNext    = INVULN;
              timerLoad    = 1'b1;
              timerLoadVal = 8'(INVULN_FRAMES);
              blinkNext    = '0;
              visNext      = 1'b0;
            end else begin
              lifeNext  = '0;
              stateNext = GAME_OVER;
            end
          end else if (lifeGain) begin
            lifeNext = life_inc(currLife, MAX_L);
          end
        end
        INVULN: begin
          if (lifeGain) lifeNext = life_inc(currLife, MAX_L);
          if (startOfFrame) begin
            if (timerDone) begin
              stateNext = ALIVE;
              visNext   = 1'b1;
              blinkNext = '0;
            end else if (blinkInc == BLINK_L) begin
              blinkNext = '0;
              visNext   = ~iconVisible;
            end else begin
              blinkNext = blinkInc;
            end
          end
        end
        GAME_OVER: begin
          lifeNext = '0;
          visNext  = 1'b1;
        end
        default: begin
          stateNext = ALIVE;
          visNext   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= ALIVE;
      currLife     <= INIT_L;
      blinkCnt     <= '0;
      iconVisible  <= 1'b1;
      invulnerable <= 1'b0;
      gameOver     <= 1'b0;
      hitPrev      <= 1'b0;
    end else begin
      state        <= stateNext;
      currLife     <= lifeNext;
      blinkCnt     <= blinkNext;
      iconVisible  <= visNext;
      invulnerable <= (stateNext == INVULN);
      gameOver     <= (stateNext == GAME_OVER);
      hitPrev      <= hitEvent;
    end
  end

endmodule

// File: tb/tb_life_manager.sv
// tb/tb_life_manager.sv - directed self-checking bench for life_manager
module tb_life_manager;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       hitEvent = 1'b0;
  logic       lifeGain = 1'b0;
  logic       newGame = 1'b0;
  logic [2:0] currLife;
  logic       invulnerable;
  logic       iconVisible;
  logic       gameOver;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  life_manager dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .hitEvent     (hitEvent),
    .lifeGain     (lifeGain),
    .newGame      (newGame),
    .currLife     (currLife),
    .invulnerable (invulnerable),
    .iconVisible  (iconVisible),
    .gameOver     (gameOver)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    startOfFrame = 1'b0; hitEvent = 1'b0; lifeGain = 1'b0; newGame = 1'b0;
    resetN = 1'b0;
    step();
    step();
    resetN = 1'b1;
    step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1; step();
      startOfFrame = 1'b0; step();
    end
  endtask

  task automatic hit_pulse();
    hitEvent = 1'b1; step();
    hitEvent = 1'b0; step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (currLife !== 3'd3) begin errors++; $display("FAIL reset_life got=%0d exp=3", currLife); end
    checks++; if ({invulnerable, iconVisible, gameOver} !== 3'b010) begin errors++; $display("FAIL reset_flags got=%b exp=010", {invulnerable, iconVisible, gameOver}); end
  endtask

  task automatic test_hit_invuln();
    do_reset();
    hitEvent = 1'b1; step();
    checks++; if (currLife !== 3'd2) begin errors++; $display("FAIL hit_life got=%0d exp=2", currLife); end
    checks++; if ({invulnerable, iconVisible} !== 2'b10) begin errors++; $display("FAIL hit_flags got=%b exp=10", {invulnerable, iconVisible}); end
    hitEvent = 1'b0; step();
    frames(119);
    checks++; if (invulnerable !== 1'b1) begin errors++; $display("FAIL invuln_119 got=%b exp=1", invulnerable); end
    frames(1);
    checks++; if ({invulnerable, iconVisible} !== 2'b01) begin errors++; $display("FAIL invuln_exit got=%b exp=01", {invulnerable, iconVisible}); end
    checks++; if (currLife !== 3'd2) begin errors++; $display("FAIL exit_life got=%0d exp=2", currLife); end
  endtask

  task automatic test_sof_with_hit();
    do_reset();
    hitEvent = 1'b1; startOfFrame = 1'b1; step();
    hitEvent = 1'b0; startOfFrame = 1'b0; step();
    frames(119);
    checks++; if (invulnerable !== 1'b1) begin errors++; $display("FAIL sof_entry_119 got=%b exp=1", invulnerable); end
    frames(1);
    checks++; if (invulnerable !== 1'b0) begin errors++; $display("FAIL sof_entry_120 got=%b exp=0", invulnerable); end
  endtask

  task automatic test_held_hit();
    do_reset();
    hitEvent = 1'b1;
    repeat (500) step();
    checks++; if (currLife !== 3'd2) begin errors++; $display("FAIL held_life got=%0d exp=2", currLife); end
    hitEvent = 1'b0; step();
    hitEvent = 1'b1; step();
    hitEvent = 1'b0; step();
    checks++; if (currLife !== 3'd2) begin errors++; $display("FAIL invuln_ignore got=%0d exp=2", currLife); end
  endtask

  task automatic test_game_over();
    do_reset();
    hit_pulse(); frames(120);
    hit_pulse(); frames(120);
    checks++; if ({currLife, invulnerable} !== {3'd1, 1'b0}) begin errors++; $display("FAIL go_pre got=%0d/%b exp=1/0", currLife, invulnerable); end
    hitEvent = 1'b1; step();
    checks++; if ({currLife, gameOver} !== {3'd0, 1'b1}) begin errors++; $display("FAIL go_enter got=%0d/%b exp=0/1", currLife, gameOver); end
    hitEvent = 1'b0; step();
    lifeGain = 1'b1; step(); lifeGain = 1'b0; step();
    checks++; if (currLife !== 3'd0) begin errors++; $display("FAIL go_gain got=%0d exp=0", currLife); end
    hitEvent = 1'b1; step();
    newGame = 1'b1; step(); newGame = 1'b0;
    checks++; if ({currLife, gameOver, invulnerable} !== {3'd3, 1'b0, 1'b0}) begin errors++; $display("FAIL newgame got=%0d/%b/%b exp=3/0/0", currLife, gameOver, invulnerable); end
    repeat (3) step();
    checks++; if (currLife !== 3'd3) begin errors++; $display("FAIL newgame_held got=%0d exp=3", currLife); end
    hitEvent = 1'b0; step();
  endtask

  task automatic test_saturate();
    logic [2:0] expv [4];
    expv[0] = 3'd4; expv[1] = 3'd5; expv[2] = 3'd5; expv[3] = 3'd5;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lifeGain = 1'b1; step(); lifeGain = 1'b0;
      checks++; if (currLife !== expv[i]) begin errors++; $display("FAIL sat_%0d got=%0d exp=%0d", i, currLife, expv[i]); end
      step();
    end
  endtask

  task automatic test_blink();
    do_reset();
    hit_pulse();
    frames(7);
    checks++; if (iconVisible !== 1'b0) begin errors++; $display("FAIL blink_f7 got=%b exp=0", iconVisible); end
    frames(1);
    checks++; if (iconVisible !== 1'b1) begin errors++; $display("FAIL blink_f8 got=%b exp=1", iconVisible); end
    frames(7);
    checks++; if (iconVisible !== 1'b1) begin errors++; $display("FAIL blink_f15 got=%b exp=1", iconVisible); end
    frames(1);
    checks++; if (iconVisible !== 1'b0) begin errors++; $display("FAIL blink_f16 got=%b exp=0", iconVisible); end
    resetN = 1'b0; #2;
    checks++; if ({currLife, invulnerable, iconVisible} !== {3'd3, 1'b0, 1'b1}) begin errors++; $display("FAIL reset_mid got=%0d/%b/%b exp=3/0/1", currLife, invulnerable, iconVisible); end
    step(); resetN = 1'b1; step();
  endtask

  task automatic test_hit_gain_at_one();
    do_reset();
    hit_pulse(); frames(120);
    hit_pulse(); frames(120);
    hitEvent = 1'b1; lifeGain = 1'b1; step();
    hitEvent = 1'b0; lifeGain = 1'b0;
    checks++; if ({currLife, invulnerable, gameOver} !== {3'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL hit_gain got=%0d/%b/%b exp=1/1/0", currLife, invulnerable, gameOver); end
    step();
  endtask

  initial begin
    test_reset();
    test_hit_invuln();
    test_sof_with_hit();
    test_held_hit();
    test_game_over();
    test_saturate();
    test_blink();
    test_hit_gain_at_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
